icache_line_refill: RTL and testbench
=====================================

// Module: icache_line_refill
// PURPOSE
//  Miss handler feeding the instruction cache's line-fill input (dataline/address).
//  On a cache miss it fetches the four 32-bit words of the missing line from
//  instruction memory over a req/ack word port and packs them into one 128-bit line.
//  It then presents the line, with its address, for the cache to store.
//  Sits between the cache's hit/miss output and the instruction memory.
// PARAMETERS
//  TIMEOUT_CYC  255  max cycles a word request may wait for mem_ack before abort (1..255)
// PORTS
//  clk          in   1    single clock, rising edge
//  rst_n        in   1    synchronous active-low reset
//  miss_req     in   1    cache missed on miss_addr; sampled only in IDLE
//  miss_addr    in   32   byte address of the missing instruction
//  busy         out  1    refill in progress (state != IDLE)
//  mem_req      out  1    word read request, held until acked
//  mem_addr     out  32   word-aligned read address
//  mem_ack      in   1    read done; mem_rdata valid this cycle
//  mem_rdata    in   32   read data
//  fill_valid   out  1    1-cycle pulse: fill_line/fill_addr are a complete line
//  fill_line    out  128  packed line; word offset k at bits [127-32k -: 32]
//  fill_addr    out  32   line base address {miss_addr[31:4],4'b0}
//  crit_valid   out  1    1-cycle pulse: requested word available early (see CONFIGURATION)
//  crit_word    out  32   requested word
//  refill_err   out  1    1-cycle pulse: refill aborted on timeout
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; all outputs 0 incl. fill_line, fill_addr,
//  mem_addr, crit_word; word and timeout counters 0. Reset mid-refill abandons it
//  without fill_valid or refill_err.
//  States: IDLE -> FETCH -> DONE -> IDLE; FETCH -> IDLE on timeout.
//  IDLE: miss_req=1 latches base={miss_addr[31:4],4'b0} and start word s, goes to FETCH.
//   mem_ack in IDLE/DONE ignored. miss_req outside IDLE ignored (not queued).
//  FETCH: mem_req=1, mem_addr=base+4*w, w = current word offset. On mem_ack:
//   mem_rdata written to fill_line slot w; w advances mod 4; timeout counter cleared.
//   The next request goes out the following cycle (mem_req stays high back-to-back).
//   After the 4th ack: mem_req=0 next cycle, go to DONE.
//  DONE: fill_valid=1 for exactly one cycle, fill_addr=base; then IDLE.
//   fill_line/fill_addr hold their values until the next refill writes them.
//   fill_line updates during FETCH; consumers use it only with fill_valid.
//  Latency (mem acks in the same cycle as req): miss_req sampled at edge 0,
//   acks at edges 1-4, fill_valid high during cycle 5; busy high cycles 1-5.
//  Timeout: counter increments each FETCH cycle without ack. At TIMEOUT_CYC:
//   refill_err pulses 1 cycle, mem_req drops, -> IDLE, no fill_valid. Partial
//   fill_line contents are kept but are not valid.
//  Ack on the timeout cycle takes priority: the word is accepted, no error.
//  Address arithmetic is 32-bit; base+4*w never carries out of the line (w<=3).
// CONFIGURATION
//  ICACHE_REFILL_CWF_EN defined: critical-word-first. s=miss_addr[3:2]; order
//   s,s+1,.. mod 4. On the first ack, crit_valid pulses with crit_word=mem_rdata.
//  Not defined: s=0, order 0,1,2,3. crit_valid and crit_word are tied to 0.
//  The fill_line layout, fill_valid timing and timeout behaviour are identical in both builds.
// TESTING
//  1 miss_addr=0x0000_0048, zero-wait mem returning addr^0xA5A5_0000 -> mem_addr
//    0x40,0x44,0x48,0x4C; fill_valid at cycle 5; fill_addr=0x40;
//    fill_line[127:96]=0xA5A5_0040, fill_line[31:0]=0xA5A5_004C.
//  2 CWF build, miss_addr=0x0000_0048 -> order 0x48,0x4C,0x40,0x44; crit_valid with
//    crit_word=0xA5A5_0048 on the first ack; same fill_line as test 1.
//  3 mem_ack delayed 3 cycles per word; miss_req pulsed again mid-refill ->
//    single fill_valid at cycle 17; second miss ignored; busy continuous.
//  4 TIMEOUT_CYC=8, mem never acks word 2 -> refill_err pulse 8 cycles after that
//    request; no fill_valid; IDLE next; a new miss then completes normally.
//  5 rst_n=0 after 2nd ack -> next cycle all outputs 0, IDLE; no fill_valid;
//    a following miss refills from word s.
//  6 mem_ack asserted while IDLE, with no miss -> no state change; fill_line unchanged.

Source files
------------

// File: rtl/icache_line_refill.sv
// icache_line_refill: fetches a 4-word instruction line over a req/ack port and presents it as one 128-bit fill.
// Define ICACHE_REFILL_CWF_EN to fetch the missed word first and pulse crit_valid with it.
module icache_line_refill #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         miss_req,
    input  logic [31:0]  miss_addr,
    output logic         busy,
    output logic         mem_req,
    output logic [31:0]  mem_addr,
    input  logic         mem_ack,
    input  logic [31:0]  mem_rdata,
    output logic         fill_valid,
    output logic [127:0] fill_line,
    output logic [31:0]  fill_addr,
    output logic         crit_valid,
    output logic [31:0]  crit_word,
    output logic         refill_err
);
    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
    state_t      r_state;
    logic [27:0] r_base;
    logic [1:0]  r_w;
    logic [1:0]  r_n;
    logic [7:0]  r_tmo;
    logic [1:0]  w_start;
    logic [6:0]  w_lsb;
    logic        w_unused;
    assign w_unused = ^miss_addr[3:0];
    assign busy     = r_state != IDLE;
    assign mem_addr = {r_base, r_w, 2'b00};
    // slot k sits at [127-32k -: 32], i.e. its lsb is 32*(3-k) = {~k, 5'b0}
    assign w_lsb    = {~r_w, 5'b0};
`ifdef ICACHE_REFILL_CWF_EN
    logic        r_crit_valid;
    logic [31:0] r_crit_word;
    assign w_start    = miss_addr[3:2];
    assign crit_valid = r_crit_valid;
    assign crit_word  = r_crit_word;
`else
    assign w_start    = 2'd0;
    assign crit_valid = 1'b0;
    assign crit_word  = 32'd0;
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_w        <= '0;
            r_n        <= '0;
            r_tmo      <= '0;
            mem_req    <= 1'b0;
            fill_valid <= 1'b0;
            fill_line  <= '0;
            fill_addr  <= '0;
            refill_err <= 1'b0;
`ifdef ICACHE_REFILL_CWF_EN
            r_crit_valid <= 1'b0;
            r_crit_word  <= '0;
`endif
        end else begin
            fill_valid <= 1'b0;
            refill_err <= 1'b0;
`ifdef ICACHE_REFILL_CWF_EN
            r_crit_valid <= 1'b0;
`endif
            case (r_state)
                IDLE: if (miss_req) begin
                    r_base  <= miss_addr[31:4];
                    r_w     <= w_start;
                    r_n     <= '0;
                    r_tmo   <= '0;
                    mem_req <= 1'b1;
                    r_state <= FETCH;
                end
                FETCH: if (mem_ack) begin
                    fill_line[w_lsb +: 32] <= mem_rdata;
                    r_w   <= r_w + 2'd1;
                    r_n   <= r_n + 2'd1;
                    r_tmo <= '0;
`ifdef ICACHE_REFILL_CWF_EN
                    if (r_n == 2'd0) begin
                        r_crit_valid <= 1'b1;
                        r_crit_word  <= mem_rdata;
                    end
`endif
                    if (r_n == 2'd3) begin
                        mem_req    <= 1'b0;
                        fill_valid <= 1'b1;
                        fill_addr  <= {r_base, 4'b0};
                        r_state    <= DONE;
                    end
                end else if (r_tmo == TMO_LAST) begin
                    mem_req    <= 1'b0;
                    refill_err <= 1'b1;
                    r_state    <= IDLE;
                end else begin
                    r_tmo <= r_tmo + 8'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_line_refill.sv
// tb_icache_line_refill: directed tests against a transaction-level refill model checked every cycle.
// Honours ICACHE_REFILL_CWF_EN the same way the design does.
module tb_icache_line_refill;
    localparam int TMO = 8;
`ifdef ICACHE_REFILL_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif
    logic         clk = 1'b0, rst_n = 1'b0, miss_req = 1'b0, mem_ack = 1'b0;
    logic [31:0]  miss_addr = '0, mem_rdata = '0;
    logic         busy, mem_req, fill_valid, crit_valid, refill_err;
    logic [31:0]  mem_addr, fill_addr, crit_word;
    logic [127:0] fill_line;

    always #5 clk = ~clk;

    icache_line_refill #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .miss_req(miss_req), .miss_addr(miss_addr),
        .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .fill_valid(fill_valid), .fill_line(fill_line),
        .fill_addr(fill_addr), .crit_valid(crit_valid), .crit_word(crit_word),
        .refill_err(refill_err)
    );

    int total = 0, bad = 0;
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // memory responder: acks after d idle cycles, can refuse one address, can ack spuriously
    int          d = 0, wcnt = 0;
    logic        blk = 1'b0, stray = 1'b0;
    logic [31:0] blk_addr = '0;
    always @(negedge clk) begin
        if (stray) begin
            mem_ack = 1'b1;
            mem_rdata = 32'hDEAD_BEEF;
        end else if (mem_req && !(blk && mem_addr == blk_addr) && wcnt >= d) begin
            mem_ack = 1'b1;
            mem_rdata = mem_addr ^ 32'hA5A5_0000;
            wcnt = 0;
        end else begin
            mem_ack = 1'b0;
            wcnt = mem_req ? wcnt + 1 : 0;
        end
    end

    // reference model: phase 0 idle, 1 fetching, 2 presenting the line
    int          cyc = 0, e0 = 0, ph = 0, m_s = 0, m_k = 0, m_wt = 0;
    logic [31:0] m_base = '0, e_fa = '0, e_cw = '0;
    logic [31:0] m_line [4];
    logic        e_fv = 1'b0, e_err = 1'b0, e_cv = 1'b0;
    logic [31:0] ackq [$];
    always @(posedge clk) begin
        cyc++;
        if (rst_n && mem_req && mem_ack) ackq.push_back(mem_addr);
        e_fv = 1'b0; e_err = 1'b0; e_cv = 1'b0;
        if (!rst_n) begin
            ph = 0; m_base = '0; m_s = 0; m_k = 0; m_wt = 0; e_fa = '0; e_cw = '0;
            foreach (m_line[i]) m_line[i] = '0;
        end else if (ph == 0) begin
            if (miss_req) begin
                ph = 1; m_base = miss_addr & ~32'hF; m_s = CWF ? int'(miss_addr[3:2]) : 0;
                m_k = 0; m_wt = 0; e0 = cyc;
            end
        end else if (ph == 1) begin
            if (mem_ack) begin
                m_line[(m_s + m_k) % 4] = mem_rdata;
                if (CWF && m_k == 0) begin e_cv = 1'b1; e_cw = mem_rdata; end
                m_k++; m_wt = 0;
                if (m_k == 4) begin ph = 2; e_fv = 1'b1; e_fa = m_base; end
            end else begin
                m_wt++;
                if (m_wt == TMO) begin ph = 0; e_err = 1'b1; end
            end
        end else ph = 0;
    end

    int           fv_n = 0, fv_rel = 0, fv_run = 0, err_n = 0, err_rel = 0, cv_n = 0, cv_rel = 0, busy_run = 0;
    logic [127:0] fv_line = '0;
    logic [31:0]  fv_addr = '0, cv_word = '0;
    always @(posedge clk) begin
        #1;
        chk("busy", busy, ph != 0);
        chk("mem_req", mem_req, ph == 1);
        if (ph == 1) chk("mem_addr", mem_addr, m_base + 32'(4 * ((m_s + m_k) % 4)));
        chk("fill_valid", fill_valid, e_fv);
        chk("fill_line", fill_line, {m_line[0], m_line[1], m_line[2], m_line[3]});
        chk("fill_addr", fill_addr, e_fa);
        chk("refill_err", refill_err, e_err);
        chk("crit_valid", crit_valid, e_cv);
        chk("crit_word", crit_word, e_cw);
        busy_run = busy ? busy_run + 1 : 0;
        if (fill_valid) begin fv_n++; fv_rel = cyc - e0; fv_line = fill_line; fv_addr = fill_addr; fv_run = busy_run; end
        if (refill_err) begin err_n++; err_rel = cyc - e0; end
        if (crit_valid) begin cv_n++; cv_rel = cyc - e0; cv_word = crit_word; end
    end

    task automatic miss(input logic [31:0] a);
        @(negedge clk); miss_addr = a; miss_req = 1'b1;
        @(negedge clk); miss_req = 1'b0;
    endtask
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic chk_zero(input string nm);
        chk({nm, "_busy"}, busy, 0); chk({nm, "_req"}, mem_req, 0); chk({nm, "_maddr"}, mem_addr, 0);
        chk({nm, "_fv"}, fill_valid, 0); chk({nm, "_line"}, fill_line, 0); chk({nm, "_faddr"}, fill_addr, 0);
        chk({nm, "_cv"}, crit_valid, 0); chk({nm, "_cw"}, crit_word, 0); chk({nm, "_err"}, refill_err, 0);
    endtask

    logic [31:0] ord [4];
    initial begin
        ord = CWF ? '{32'h48, 32'h4C, 32'h40, 32'h44} : '{32'h40, 32'h44, 32'h48, 32'h4C};
        idle(3);
        chk_zero("rst");
        rst_n = 1'b1;
        // 1/2: zero-wait refill of the line holding 0x48
        ackq.delete(); miss(32'h48); idle(10);
        chk("t1_nfill", fv_n, 1); chk("t1_rel", fv_rel, 4); chk("t1_busy", fv_run, 5);
        chk("t1_faddr", fv_addr, 32'h40);
        chk("t1_w0", fv_line[127:96], 32'hA5A5_0040); chk("t1_w3", fv_line[31:0], 32'hA5A5_004C);
        chk("t1_line", fv_line, 128'hA5A50040_A5A50044_A5A50048_A5A5004C);
        chk("t1_nack", ackq.size(), 4);
        for (int i = 0; i < 4; i++) chk("t1_order", ackq[i], ord[i]);
        chk("t2_ncrit", cv_n, CWF ? 1 : 0);
        if (CWF) begin chk("t2_crit", cv_word, 32'hA5A5_0048); chk("t2_crel", cv_rel, 1); end
        // 3: three wait cycles per word, second miss mid-refill is dropped
        d = 3; ackq.delete(); miss(32'h1230); idle(5); miss(32'h5550); idle(25); d = 0;
        chk("t3_nfill", fv_n, 2); chk("t3_rel", fv_rel, 16); chk("t3_busy", fv_run, 17);
        chk("t3_faddr", fv_addr, 32'h1230); chk("t3_nack", ackq.size(), 4);
        // 4: word 2 never acked -> timeout, then a clean refill
        blk = 1'b1; blk_addr = 32'h108; miss(32'h100); idle(20); blk = 1'b0;
        chk("t4_nerr", err_n, 1); chk("t4_rel", err_rel, 10); chk("t4_nfill", fv_n, 2);
        miss(32'h200); idle(10);
        chk("t4_nfill2", fv_n, 3); chk("t4_faddr", fv_addr, 32'h200); chk("t4_nerr2", err_n, 1);
        // 5: reset after the second ack
        miss(32'h300); idle(2); rst_n = 1'b0;
        @(negedge clk);
        chk_zero("t5");
        rst_n = 1'b1;
        chk("t5_nfill", fv_n, 3);
        ackq.delete(); miss(32'h304); idle(10);
        chk("t5_nfill2", fv_n, 4); chk("t5_faddr", fv_addr, 32'h300);
        chk("t5_first", ackq.size() > 0 ? ackq[0] : 32'hFFFF_FFFF, CWF ? 32'h304 : 32'h300);
        // 6: spurious acks while idle
        stray = 1'b1; idle(4); stray = 1'b0; idle(2);
        chk("t6_line", fill_line, 128'hA5A50300_A5A50304_A5A50308_A5A5030C);
        chk("t6_busy", busy, 0); chk("t6_nfill", fv_n, 4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
